pp_stream_rr_arbiter: RTL and testbench

- Round-robin arbiter merging NUM_IN HLS ap_fifo-style input streams into one output stream, each grant held for a programmable burst of beats.
- Sits between several upstream pipeline FIFOs (read side: empty_n/read/dout) and one downstream FIFO (write side: full_n/write/din) in the pp_pipeline_accel datapath.
- The data path is combinational fall-through.
- The block only sequences which source is drained, and when.

---
 rtl/pp_stream_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_pp_stream_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_stream_rr_arbiter.sv
// Round-robin arbiter draining NUM_IN ap_fifo streams into one output,
// holding each grant for a programmable burst with starvation release.
module pp_stream_rr_arbiter #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_W    = 8,
   parameter int TMO_W      = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [BURST_W-1:0]           burst_len,
   input  logic [TMO_W-1:0]             tmo_len,
   input  logic [NUM_IN-1:0]            in_empty_n,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
   output logic [NUM_IN-1:0]            in_read,
   input  logic                         out_full_n,
   output logic                         out_write,
   output logic [DATA_WIDTH-1:0]        out_din,
   output logic [$clog2(NUM_IN)-1:0]    grant_id,
   output logic                         busy,
   output logic [BURST_W-1:0]           beat_cnt
);

   localparam int GW = $clog2(NUM_IN);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [BURST_W-1:0] beat_q, beat_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [TMO_W-1:0]   tmo_len_q, tmo_len_d;

   logic [DATA_WIDTH-1:0] src [NUM_IN];
   logic [GW-1:0]         pick;
   logic [GW-1:0]         cand;
   logic                  found;
   logic                  xfer;
   logic [TMO_W-1:0]      tmo_inc;

   for (genvar i = 0; i < NUM_IN; i++) begin : g_src
      assign src[i] = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Circular search starting just past the last granted source
   always_comb begin
      pick  = grant_q;
      cand  = grant_q;
      found = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
         cand = GW'((int'(grant_q) + k) % NUM_IN);
         if (!found && in_empty_n[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign xfer = (state_q == S_GRANT) && in_empty_n[grant_q] && out_full_n;

   always_comb begin
      in_read = '0;
      if (xfer) in_read[grant_q] = 1'b1;
   end

   assign out_write = xfer;
   assign out_din   = xfer ? src[grant_q] : '0;
   assign grant_id  = grant_q;
   assign busy      = (state_q == S_GRANT);
   assign beat_cnt  = beat_q;

   assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      burst_d   = burst_q;
      beat_d    = beat_q;
      tmo_d     = tmo_q;
      tmo_len_d = tmo_len_q;
      case (state_q)
         S_IDLE: begin
            if (enable && found) begin
               state_d   = S_GRANT;
               grant_d   = pick;
               burst_d   = (burst_len == '0) ? BURST_W'(1) : burst_len;
               tmo_len_d = tmo_len;
               beat_d    = '0;
               tmo_d     = '0;
            end
         end
         S_GRANT: begin
            if (xfer) begin
               tmo_d = '0;
               if (beat_q == burst_q - 1'b1) begin
                  state_d = S_IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end else if (out_full_n) begin
               // Only starvation counts; a full downstream freezes the timer
               tmo_d = tmo_inc;
               if (tmo_len_q != '0 && tmo_inc >= tmo_len_q) begin
                  state_d = S_IDLE;
                  beat_d  = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         grant_q   <= GW'(NUM_IN - 1);
         burst_q   <= '0;
         beat_q    <= '0;
         tmo_q     <= '0;
         tmo_len_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         burst_q   <= burst_d;
         beat_q    <= beat_d;
         tmo_q     <= tmo_d;
         tmo_len_q <= tmo_len_d;
      end
   end

endmodule

// File: tb/tb_pp_stream_rr_arbiter.sv
// Bench for pp_stream_rr_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_pp_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int BW = 8;
   localparam int TW = 4;

   logic          clk;
   logic          reset;
   logic          enable;
   logic [BW-1:0] burst_len;
   logic [TW-1:0] tmo_len;
   logic [N-1:0]  in_empty_n;
   logic [N*DW-1:0] in_dout;
   logic [N-1:0]  in_read;
   logic          out_full_n;
   logic          out_write;
   logic [DW-1:0] out_din;
   logic [1:0]    grant_id;
   logic          busy;
   logic [BW-1:0] beat_cnt;

   pp_stream_rr_arbiter #(
      .NUM_IN(N), .DATA_WIDTH(DW), .BURST_W(BW), .TMO_W(TW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .burst_len(burst_len), .tmo_len(tmo_len),
      .in_empty_n(in_empty_n), .in_dout(in_dout), .in_read(in_read),
      .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din),
      .grant_id(grant_id), .busy(busy), .beat_cnt(beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: owner, beats left in burst, beats done, starvation
   int m_busy, m_owner, m_left, m_done, m_starve, m_tmo;

   int       gq[$];
   int       wcnt;
   int       maxbeat;
   logic [31:0] wpat;
   logic     prev_busy;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_busy = 0; m_owner = N - 1; m_left = 0;
      m_done = 0; m_starve = 0; m_tmo = 0;
      prev_busy = 1'b0;
   endtask

   task automatic clr_log();
      gq.delete();
      wcnt = 0; maxbeat = 0; wpat = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'(N - 1));
      chk("rst_beat", 32'(beat_cnt), 32'd0);
      chk("rst_read", 32'(in_read), 32'd0);
      chk("rst_write", 32'(out_write), 32'd0);
      chk("rst_din", 32'(out_din), 32'd0);
      reset = 1'b0;
      m_reset();
      clr_log();
   endtask

   task automatic tick();
      logic x;
      int   s;
      logic [DW-1:0] d;
      in_dout = {$urandom(), $urandom()};
      @(negedge clk);
      x = (m_busy != 0) && in_empty_n[m_owner] && out_full_n;
      d = in_dout[m_owner*DW +: DW];
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_owner));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_done));
      chk("out_write", 32'(out_write), 32'(x));
      chk("in_read", 32'(in_read), x ? 32'(1 << m_owner) : 32'd0);
      chk("out_din", 32'(out_din), x ? 32'(d) : 32'd0);
      if (busy && !prev_busy) gq.push_back(int'(grant_id));
      prev_busy = busy;
      wcnt += int'(out_write);
      wpat = {wpat[30:0], out_write};
      if (int'(beat_cnt) > maxbeat) maxbeat = int'(beat_cnt);
      if (m_busy == 0) begin
         if (enable && (in_empty_n != '0)) begin
            for (int k = 1; k <= N; k++) begin
               s = (m_owner + k) % N;
               if (in_empty_n[s]) break;
            end
            m_owner  = s;
            m_busy   = 1;
            m_left   = (burst_len == 0) ? 1 : int'(burst_len);
            m_done   = 0;
            m_starve = 0;
            m_tmo    = int'(tmo_len);
         end
      end else if (x) begin
         m_done++;
         m_left--;
         m_starve = 0;
         if (m_left == 0) begin
            m_busy = 0;
            m_done = 0;
         end
      end else if (out_full_n) begin
         if (m_starve < (1 << TW) - 1) m_starve++;
         if (m_tmo != 0 && m_starve >= m_tmo) begin
            m_busy = 0;
            m_done = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic int gat(input int i);
      return (i < gq.size()) ? gq[i] : -1;
   endfunction

   initial begin
      int e1 [4];
      int e2 [5];
      e1 = '{0, 2, 0, 2};
      e2 = '{0, 1, 2, 3, 0};
      reset = 1'b1; enable = 1'b0; burst_len = '0; tmo_len = '0;
      in_empty_n = '0; in_dout = '0; out_full_n = 1'b1;
      m_reset();
      clr_log();

      // 1: two sources, burst 3
      do_reset();
      enable = 1'b1; burst_len = 8'd3; in_empty_n = 4'b0101;
      run(16);
      chk("s1_ngrants", 32'(gq.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("s1_order", 32'(gat(i)), 32'(e1[i]));
      chk("s1_writes", 32'(wcnt), 32'd12);

      // 2: all requesting, burst 1
      do_reset();
      enable = 1'b1; burst_len = 8'd1; in_empty_n = 4'b1111;
      run(10);
      for (int i = 0; i < 5; i++) chk("s2_order", 32'(gat(i)), 32'(e2[i]));
      chk("s2_wpat", 32'(wpat[9:0]), 32'h155);

      // 3: backpressure stall mid-burst
      do_reset();
      enable = 1'b1; burst_len = 8'd8; in_empty_n = 4'b0010;
      run(4);
      out_full_n = 1'b0;
      run(5);
      chk("s3_stall_busy", 32'(busy), 32'd1);
      out_full_n = 1'b1;
      run(5);
      chk("s3_writes", 32'(wcnt), 32'd8);
      chk("s3_maxbeat", 32'(maxbeat), 32'd7);
      chk("s3_released", 32'(busy), 32'd0);

      // 4: starvation timeout; tmo_len change mid-burst ignored
      do_reset();
      enable = 1'b1; burst_len = 8'd16; tmo_len = 4'd4;
      in_empty_n = 4'b1000;
      run(3);
      in_empty_n = 4'b0001; tmo_len = 4'd1;
      run(3);
      chk("s4_beat", 32'(beat_cnt), 32'd2);
      chk("s4_still", 32'(busy), 32'd1);
      run(1);
      chk("s4_release", 32'(busy), 32'd0);
      run(1);
      chk("s4_next", 32'(grant_id), 32'd0);
      chk("s4_next_busy", 32'(busy), 32'd1);

      // 5: enable dropped mid-burst
      do_reset();
      enable = 1'b1; burst_len = 8'd4; tmo_len = '0; in_empty_n = 4'b1111;
      run(2);
      enable = 1'b0;
      run(8);
      chk("s5_writes", 32'(wcnt), 32'd4);
      chk("s5_idle", 32'(busy), 32'd0);
      chk("s5_ngrants", 32'(gq.size()), 32'd1);

      // 6: asynchronous reset mid-burst
      do_reset();
      enable = 1'b1; burst_len = 8'd8; in_empty_n = 4'b1111;
      run(3);
      #2 reset = 1'b1;
      #1;
      chk("s6_read", 32'(in_read), 32'd0);
      chk("s6_write", 32'(out_write), 32'd0);
      chk("s6_busy", 32'(busy), 32'd0);
      chk("s6_beat", 32'(beat_cnt), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_reset();
      clr_log();
      run(2);
      chk("s6_first", 32'(gat(0)), 32'd0);

      // 7: random traffic
      for (int i = 0; i < 800; i++) begin
         if (i == 400) do_reset();
         enable     = ($urandom_range(0, 9) != 0);
         burst_len  = BW'($urandom_range(0, 5));
         tmo_len    = TW'($urandom_range(0, 5));
         in_empty_n = N'($urandom());
         out_full_n = ($urandom_range(0, 4) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
